// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C target front-end with synchronised, glitch-filtered SCL/SDA and a byte interface.
// Define I2C_SLAVE_CLK_STRETCH_EN to add scl_oe/tx_valid clock stretching while waiting for read data.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  output logic       scl_oe,
  input  logic       tx_valid,
`endif
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_e;
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] sync_d [SYNC_STAGES];
  logic [2:0] fcnt_q [2];
  logic [2:0] fcnt_d [2];
  logic [1:0] filt_q, filt_d;
  logic scl_rise, scl_fall, sda_s, start_c, stop_c, lat_ev, tv;
  state_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d;
  logic str_q, str_d, sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic start_q, start_d, stop_q, stop_d, busy_q, busy_d;
  // bit 1 carries SCL, bit 0 carries SDA through synchroniser and filter
  always_comb begin
    sync_d[0] = {scl_i, sda_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_comb begin
    filt_d = filt_q;
    for (int k = 0; k < 2; k++) begin
      fcnt_d[k] = 3'd0;
      if (sync_q[SYNC_STAGES-1][k] != filt_q[k]) begin
        fcnt_d[k] = fcnt_q[k] + 3'd1;
        if (fcnt_d[k] == 3'(FILTER_LEN)) begin
          filt_d[k] = sync_q[SYNC_STAGES-1][k];
          fcnt_d[k] = 3'd0;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
      fcnt_q[0] <= 3'd0;
      fcnt_q[1] <= 3'd0;
      filt_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  assign scl_rise = filt_d[1] & ~filt_q[1];
  assign scl_fall = ~filt_d[1] & filt_q[1];
  assign sda_s = filt_q[0];
  assign start_c = ~filt_d[0] & filt_q[0] & filt_q[1];
  assign stop_c = filt_d[0] & ~filt_q[0] & filt_q[1];
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign tv = tx_valid;
`else
  assign tv = 1'b1;
`endif
  // read data is fetched on the ACK falling edge after a read address or a master ACK
  assign lat_ev = str_q | (scl_fall & ((st_q == ADDR_ACK & sh_q[0]) | st_q == RD_ACK));
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    tx_sh_d = tx_sh_q;
    str_d = 1'b0;
    sda_oe_d = sda_oe_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d = 1'b0;
    start_d = 1'b0;
    stop_d = 1'b0;
    busy_d = busy_q;
    if (start_c) begin
      st_d = ADDR;
      cnt_d = 4'd0;
      sda_oe_d = 1'b0;
      start_d = 1'b1;
      busy_d = 1'b1;
    end else if (stop_c) begin
      st_d = IDLE;
      sda_oe_d = 1'b0;
      stop_d = 1'b1;
      busy_d = 1'b0;
    end else if (lat_ev) begin
      if (tv) begin
        tx_sh_d = tx_data;
        sda_oe_d = ~tx_data[7];
        cnt_d = 4'd1;
        st_d = RD_DATA;
      end else str_d = 1'b1;
    end else if (scl_rise) begin
      case (st_q)
        ADDR, WR_DATA: begin
          sh_d = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          rx_data_d = (st_q == WR_DATA && cnt_q == 4'd7) ? {sh_q[6:0], sda_s} : rx_data_q;
          rx_valid_d = st_q == WR_DATA && cnt_q == 4'd7;
        end
        ADDR_ACK: tx_req_d = sh_q[0];
        RD_ACK: begin
          st_d = sda_s ? IGNORE : RD_ACK;
          tx_req_d = ~sda_s;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (st_q)
        ADDR: if (cnt_q == 4'd8) begin
          st_d = (sh_q[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
          sda_oe_d = sh_q[7:1] == SLAVE_ADDR;
        end
        ADDR_ACK: begin
          sda_oe_d = 1'b0;
          cnt_d = 4'd0;
          st_d = WR_DATA;
        end
        WR_DATA: if (cnt_q == 4'd8) begin
          sda_oe_d = 1'b1;
          cnt_d = 4'd0;
          st_d = WR_ACK;
        end
        WR_ACK: begin
          sda_oe_d = 1'b0;
          st_d = WR_DATA;
        end
        RD_DATA: begin
          sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~tx_sh_q[6];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
          cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
          st_d = (cnt_q == 4'd8) ? RD_ACK : RD_DATA;
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= 4'd0;
      sh_q <= 8'h00;
      tx_sh_q <= 8'h00;
      str_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rx_data_q <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_sh_q <= tx_sh_d;
      str_q <= str_d;
      sda_oe_q <= sda_oe_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q <= tx_req_d;
      start_q <= start_d;
      stop_q <= stop_d;
      busy_q <= busy_d;
    end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic scl_oe_q, scl_oe_d;
  // SCL is released one clk after the latch so the MSB is already on SDA
  assign scl_oe_d = str_q | str_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) scl_oe_q <= 1'b0;
    else scl_oe_q <= scl_oe_d;
  assign scl_oe = scl_oe_q;
`endif
  assign sda_oe = sda_oe_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req = tx_req_q;
  assign start_det = start_q;
  assign stop_det = stop_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: I2C master model on a wired-AND bus; a monitor scores DUT strobes against queued expectations.
`timescale 1ns/1ps
module tb_i2c_slave_core;
  localparam int Q = 10;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic sda_oe, rx_valid, tx_req, start_det, stop_det, busy, scl_bus, sda_bus;
  int errors = 0, checks = 0, oe_cnt = 0, req_cnt = 0, ev_cnt = 0, soe_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  int exp_ev[$];
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic scl_oe;
  logic tx_valid = 1'b1;
  assign scl_bus = scl_m & ~scl_oe;
`else
  assign scl_bus = scl_m;
`endif
  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_core dut (
    .clk(clk), .rst(rst), .scl_i(scl_bus), .sda_i(sda_bus ^ glitch), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    .scl_oe(scl_oe), .tx_valid(tx_valid),
`endif
    .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    int n;
    sda_m = b;
    w(Q);
    scl_m = 1'b1;
    n = 0;
    while (!scl_bus && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("scl released", scl_bus, 1);
    w(Q);
    r = sda_bus;
    w(Q);
    scl_m = 1'b0;
    w(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1;
    w(Q);
    scl_m = 1'b1;
    w(Q);
    sda_m = 1'b0;
    w(Q);
    scl_m = 1'b0;
    w(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0;
    w(Q);
    scl_m = 1'b1;
    w(Q);
    sda_m = 1'b1;
    w(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
  endtask

  // scoreboard monitor
  always @(negedge clk) if (!rst) begin
    if (sda_oe) oe_cnt++;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    if (scl_oe) soe_cnt++;
`endif
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_valid: pulse with rx_data=%h, expected no byte", rx_data);
      end else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (start_det || stop_det) begin
      ev_cnt++;
      if (exp_ev.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus event: start_det=%b stop_det=%b, expected none", start_det, stop_det);
      end else begin
        chk("event kind", start_det ? 1 : 2, exp_ev.pop_front());
        chk("busy at event", busy, start_det);
      end
    end
  end

  // read-data responder
  initial forever begin
    @(negedge clk);
    if (!rst && tx_req) begin
      req_cnt++;
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_req: pulse with tx_q empty, expected none");
      end else tx_data = tx_q.pop_front();
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  initial begin
    @(posedge scl_oe);
    repeat (20) @(negedge clk);
    tx_valid = 1'b1;
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2ms, expected finish");
    $fatal(1);
  end

  initial begin
    logic a, r;
    logic [7:0] d;
    int ev0;
    w(3);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst rx_data", rx_data, 8'h00);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst tx_req", tx_req, 0);
    chk("rst start_det", start_det, 0);
    chk("rst stop_det", stop_det, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    w(4 * Q);
    // write 0x3C, 0xFF to 0x50
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA0, a); chk("w1 addr ack", a, 0);
    exp_rx.push_back(8'h3C);
    wr_byte(8'h3C, a); chk("w1 data0 ack", a, 0);
    exp_rx.push_back(8'hFF);
    wr_byte(8'hFF, a); chk("w1 data1 ack", a, 0);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
    chk("w1 busy after stop", busy, 0);
    chk("w1 rx bytes left", exp_rx.size(), 0);
    // wrong address
    oe_cnt = 0;
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA2, a); chk("w2 addr nack", a, 1);
    wr_byte(8'h12, a); chk("w2 data nack", a, 1);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
    chk("w2 sda_oe cycles", oe_cnt, 0);
    chk("w2 busy after stop", busy, 0);
    // read 0x5A then 0xC3
    req_cnt = 0;
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA1, a); chk("r1 addr ack", a, 0);
    rd_byte(1'b0, d); chk("r1 byte0", d, 8'h5A);
    rd_byte(1'b1, d); chk("r1 byte1", d, 8'hC3);
    w(Q);
    chk("r1 sda_oe after nack", sda_oe, 0);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
    chk("r1 tx_req pulses", req_cnt, 2);
    // write then repeated START read
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA0, a); chk("rs addr ack", a, 0);
    exp_rx.push_back(8'h10);
    wr_byte(8'h10, a); chk("rs data ack", a, 0);
    exp_ev.push_back(1);
    m_start();
    chk("rs busy after rstart", busy, 1);
    tx_q.push_back(8'h77);
    wr_byte(8'hA1, a); chk("rs read addr ack", a, 0);
    rd_byte(1'b1, d); chk("rs read byte", d, 8'h77);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
    // one-clk SDA glitch with SCL high
    ev0 = ev_cnt;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    w(2 * Q);
    chk("glitch events", ev_cnt, ev0);
    chk("glitch busy", busy, 0);
    // reset in the middle of a read byte of 0x00
    tx_q.push_back(8'h00);
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA1, a); chk("rr addr ack", a, 0);
    for (int i = 0; i < 3; i++) bit_io(1'b1, r);
    chk("rr driving zero", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("rr async sda_oe", sda_oe, 0);
    chk("rr async busy", busy, 0);
    w(2);
    rst = 1'b0;
    w(2 * Q);
    scl_m = 1'b1;
    w(2 * Q);
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA0, a); chk("rr post addr ack", a, 0);
    exp_rx.push_back(8'h96);
    wr_byte(8'h96, a); chk("rr post data ack", a, 0);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
    chk("rr post busy", busy, 0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // clock stretch: tx_valid held low for 20 clks
    tx_valid = 1'b0;
    soe_cnt = 0;
    tx_q.push_back(8'h96);
    exp_ev.push_back(1);
    m_start();
    wr_byte(8'hA1, a); chk("cs addr ack", a, 0);
    rd_byte(1'b1, d); chk("cs read byte", d, 8'h96);
    chk("cs scl_oe cycles", soe_cnt, 21);
    exp_ev.push_back(2);
    m_stop();
    w(Q);
`endif
    w(2 * Q);
    chk("events left", exp_ev.size(), 0);
    chk("rx bytes left", exp_rx.size(), 0);
    chk("tx bytes left", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
